// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_RX_OVS_DEFAULT = 16;
    localparam int unsigned UART_DATA_W_MAX     = 9;

    typedef enum logic [2:0] {ParNone, ParEven, ParOdd, ParMark, ParSpace} uart_parity_e;

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StBrkWait
    } uart_rx_state_e;

    // Raw parity_mode encodings 5..7 are reserved and behave as no parity.
    function automatic uart_parity_e decode_parity(input logic [2:0] mode);
        case (mode)
            3'd1:    return ParEven;
            3'd2:    return ParOdd;
            3'd3:    return ParMark;
            3'd4:    return ParSpace;
            default: return ParNone;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every max(div_i,1) clocks, realigned by restart_i.
module uart_baud_tick #(
    parameter int unsigned DivW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            restart_i,
    input  logic [DivW-1:0] div_i,
    output logic            tick_o
);

    logic [DivW-1:0] cnt_q, cnt_d, reload;

    always_comb begin
        reload = (div_i == '0) ? '0 : div_i - DivW'(1);
        tick_o = 1'b0;
        cnt_d  = cnt_q;
        if (restart_i) begin
            cnt_d = reload;
        end else if (cnt_q == '0) begin
            tick_o = 1'b1;
            cnt_d  = reload;
        end else begin
            cnt_d = cnt_q - DivW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_core_param.sv
// Parametrised UART receiver: rx synchroniser, majority-vote frame FSM, break detection and a
// valid/ready holding register with overrun reporting.
module uart_rx_core_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W_MAX  = UART_DATA_W_MAX,
    parameter int unsigned OVS         = UART_RX_OVS_DEFAULT,
    parameter int unsigned BAUD_DIV_W  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned LenW       = $clog2(DATA_W_MAX + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [BAUD_DIV_W-1:0] baud_div_i,
    input  logic [LenW-1:0]       data_len_i,
    input  logic [2:0]            parity_mode_i,
    input  logic                  stop2_i,
    input  logic                  rx_i,
    output logic [DATA_W_MAX-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  break_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int unsigned OvsW = $clog2(OVS);
    localparam logic [OvsW-1:0] TapA    = OvsW'(OVS / 2 - 1);
    localparam logic [OvsW-1:0] TapB    = OvsW'(OVS / 2);
    localparam logic [OvsW-1:0] TapC    = OvsW'(OVS / 2 + 1);
    localparam logic [OvsW-1:0] OvsLast = OvsW'(OVS - 1);
    localparam logic [LenW-1:0] LenMin  = LenW'(5);
    localparam logic [LenW-1:0] LenMax  = LenW'(DATA_W_MAX);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q, rx_s, tick, start_edge, vote_now, vote, par_exp;
    uart_rx_state_e         state_q, state_d;
    logic [OvsW-1:0]        ovs_q, ovs_d, ovs_next;
    logic [1:0]             taps_q, taps_d;
    logic [LenW-1:0]        bit_q, bit_d, len_q, len_d, len_in;
    logic [DATA_W_MAX-1:0]  shreg_q, shreg_d, data_q, data_d;
    uart_parity_e           par_q, par_d;
    logic stop2_q, stop2_d, stop_idx_q, stop_idx_d, stop1_q, stop1_d, stop1_eff;
    logic par_bit_q, par_bit_d, perr_q, perr_d, ferr_q, ferr_d;
    logic complete, frame_done, is_break, deliver, load;
    logic valid_q, valid_d, hperr_q, hperr_d, hferr_q, hferr_d;
    logic break_q, break_d, overrun_q, overrun_d;

    uart_baud_tick #(
        .DivW(BAUD_DIV_W)
    ) u_baud_tick (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .restart_i(start_edge),
        .div_i    (baud_div_i),
        .tick_o   (tick)
    );

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = en_i & rx_prev_q & ~rx_s & (state_q == StIdle);
    assign ovs_next   = (ovs_q == OvsLast) ? '0 : ovs_q + OvsW'(1);
    assign vote_now   = tick & (ovs_next == TapC);
    assign vote       = (taps_q[0] & taps_q[1]) | (taps_q[0] & rx_s) | (taps_q[1] & rx_s);
    assign len_in     = (data_len_i < LenMin) ? LenMin :
                        (data_len_i > LenMax) ? LenMax : data_len_i;
    // With two stop bits the break decision still looks at the first one.
    assign stop1_eff  = stop_idx_q ? stop1_q : vote;
    assign is_break   = (shreg_q == '0) & ((par_q == ParNone) | ~par_bit_q) & ~stop1_eff;
    assign frame_done = complete & en_i;

    always_comb begin
        par_exp = 1'b0;
        unique case (par_q)
            ParEven: par_exp = ^shreg_q;
            ParOdd:  par_exp = ~^shreg_q;
            ParMark: par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ovs_d      = ovs_q;
        taps_d     = taps_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        len_d      = len_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        stop1_d    = stop1_q;
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        complete   = 1'b0;
        if (tick && state_q != StIdle) begin
            ovs_d = ovs_next;
            if (ovs_next == TapA) taps_d[0] = rx_s;
            if (ovs_next == TapB) taps_d[1] = rx_s;
        end
        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d    = StStart;
                    ovs_d      = '0;
                    bit_d      = '0;
                    shreg_d    = '0;
                    stop_idx_d = 1'b0;
                    par_bit_d  = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    len_d      = len_in;
                    par_d      = decode_parity(parity_mode_i);
                    stop2_d    = stop2_i;
                end
            end
            StStart: if (vote_now) state_d = vote ? StIdle : StData;
            StData: begin
                if (vote_now) begin
                    shreg_d[bit_q] = vote;
                    bit_d          = bit_q + LenW'(1);
                    if (bit_q == len_q - LenW'(1)) state_d = (par_q == ParNone) ? StStop : StParity;
                end
            end
            StParity: begin
                if (vote_now) begin
                    par_bit_d = vote;
                    perr_d    = (vote != par_exp);
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (vote_now) begin
                    if (!vote) ferr_d = 1'b1;
                    if (!stop_idx_q) stop1_d = vote;
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        complete = 1'b1;
                        state_d  = is_break ? StBrkWait : StIdle;
                    end
                end
            end
            StBrkWait: if (tick && rx_s) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (!en_i) state_d = StIdle;
    end

    always_comb begin
        deliver   = frame_done & ~is_break;
        load      = deliver & (~valid_q | rx_ready_i);
        valid_d   = load | (valid_q & ~rx_ready_i);
        data_d    = load ? shreg_q : data_q;
        hperr_d   = load ? perr_q : hperr_q;
        hferr_d   = load ? (ferr_q | ~vote) : hferr_q;
        break_d   = frame_done & is_break;
        overrun_d = deliver & ~load;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            state_q    <= StIdle;
            ovs_q      <= '0;
            taps_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            len_q      <= LenMin;
            par_q      <= ParNone;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            stop1_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            hperr_q    <= 1'b0;
            hferr_q    <= 1'b0;
            break_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_prev_q  <= rx_s;
            state_q    <= state_d;
            ovs_q      <= ovs_d;
            taps_q     <= taps_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            len_q      <= len_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            stop1_q    <= stop1_d;
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            hperr_q    <= hperr_d;
            hferr_q    <= hferr_d;
            break_q    <= break_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign parity_err_o = hperr_q;
    assign frame_err_o  = hferr_q;
    assign break_o      = break_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core_param.sv
// Bench for uart_rx_core_param: directed scenarios plus randomized frames against a frame model.
module tb_uart_rx_core_param;

    localparam int unsigned OVS = 16;

    logic        clk = 1'b0;
    logic        rst_i, en_i, stop2_i, rx_i, rx_ready_i;
    logic [15:0] baud_div_i;
    logic [3:0]  data_len_i;
    logic [2:0]  parity_mode_i;
    logic [8:0]  rx_data_o;
    logic        rx_valid_o, parity_err_o, frame_err_o, break_o, overrun_o, busy_o;

    always #5 clk = ~clk;

    uart_rx_core_param dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .baud_div_i   (baud_div_i),
        .data_len_i   (data_len_i),
        .parity_mode_i(parity_mode_i),
        .stop2_i      (stop2_i),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .break_o      (break_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    typedef struct { logic [8:0] d; logic pe; logic fe; } rec_t;
    rec_t rec_q[$];
    int   brk_cnt, ovr_cnt;
    int   n_cmp = 0, n_err = 0;

    // Every word that transfers, and every pulse cycle, is logged for the tests.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (rx_valid_o && rx_ready_i) rec_q.push_back('{rx_data_o, parity_err_o, frame_err_o});
            if (break_o)   brk_cnt++;
            if (overrun_o) ovr_cnt++;
        end
    end

    function automatic int eff_len(input int l);
        return (l < 5) ? 5 : (l > 9) ? 9 : l;
    endfunction

    function automatic int par_kind(input int m);
        return (m >= 1 && m <= 4) ? m : 0;
    endfunction

    function automatic logic par_expect(input logic [8:0] d, input int kind);
        case (kind)
            1:       return ^d;
            2:       return ~(^d);
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic clr();
        rec_q.delete();
        brk_cnt = 0;
        ovr_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int len, input int pm, input logic two, input int div);
        data_len_i    = 4'(len);
        parity_mode_i = 3'(pm);
        stop2_i       = two;
        baud_div_i    = 16'(div);
    endtask

    task automatic send_frame(input logic [8:0] d, input int el, input int kind, input logic pbit,
                              input logic s1, input logic s2, input logic two,
                              input int spike_at);
        logic [15:0] bits;
        int n, bt;
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < el; i++) begin bits[n] = d[i]; n++; end
        if (kind != 0) begin bits[n] = pbit; n++; end
        bits[n] = s1; n++;
        if (two) begin bits[n] = s2; n++; end
        bt = OVS * ((baud_div_i == 0) ? 1 : int'(baud_div_i));
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < bt; c++) begin
                rx_i = (i * bt + c == spike_at) ? ~bits[i] : bits[i];
                @(posedge clk);
                #1;
            end
        end
        rx_i = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (rx_data_o !== 9'h000) begin
            n_err++; $display("FAIL reset_data: got %h want 000", rx_data_o);
        end
        n_cmp++;
        if (rx_valid_o !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", rx_valid_o);
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b want 0", busy_o);
        end
        n_cmp++;
        if ({parity_err_o, frame_err_o, break_o, overrun_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000",
                     {parity_err_o, frame_err_o, break_o, overrun_o});
        end
    endtask

    task automatic test_basic();
        int cnt;
        set_cfg(8, 0, 1'b0, 1);
        rx_ready_i = 1'b1;
        clr();
        fork
            send_frame(9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
            begin
                cnt = 0;
                @(posedge clk);
                while (cnt < 400) begin
                    @(negedge clk);
                    cnt++;
                    if (rx_valid_o) break;
                end
                n_cmp++;
                if (cnt < 150 || cnt > 170) begin
                    n_err++; $display("FAIL basic_latency: got %0d clks want 150..170", cnt);
                end
                @(negedge clk);
                n_cmp++;
                if (rx_valid_o !== 1'b0) begin
                    n_err++; $display("FAIL basic_valid_width: got %b want 0", rx_valid_o);
                end
            end
        join
        idle(32);
        n_cmp++;
        if (rec_q.size() != 1 || rec_q[0].d !== 9'h0A5 || rec_q[0].pe || rec_q[0].fe) begin
            n_err++;
            $display("FAIL basic_word: got n=%0d d=%h pe=%b fe=%b want n=1 d=0a5 pe=0 fe=0",
                     rec_q.size(), rec_q[0].d, rec_q[0].pe, rec_q[0].fe);
        end
    endtask

    task automatic test_parity();
        logic pbit;
        rx_ready_i = 1'b1;
        pbit = ~par_expect(9'h041, 1);
        set_cfg(7, 1, 1'b0, 1);
        clr();
        send_frame(9'h041, 7, 1, pbit, 1'b1, 1'b1, 1'b0, -1);
        idle(32);
        n_cmp++;
        if (rec_q.size() != 1 || rec_q[0].d !== 9'h041 || rec_q[0].pe !== 1'b1) begin
            n_err++;
            $display("FAIL parity_even_bad: got n=%0d d=%h pe=%b want n=1 d=041 pe=1",
                     rec_q.size(), rec_q[0].d, rec_q[0].pe);
        end
        set_cfg(7, 2, 1'b0, 1);
        clr();
        send_frame(9'h041, 7, 2, pbit, 1'b1, 1'b1, 1'b0, -1);
        idle(32);
        n_cmp++;
        if (rec_q.size() != 1 || rec_q[0].d !== 9'h041 || rec_q[0].pe !== 1'b0) begin
            n_err++;
            $display("FAIL parity_odd_ok: got n=%0d d=%h pe=%b want n=1 d=041 pe=0",
                     rec_q.size(), rec_q[0].d, rec_q[0].pe);
        end
    endtask

    task automatic test_frame_err();
        set_cfg(9, 0, 1'b1, 1);
        rx_ready_i = 1'b1;
        clr();
        send_frame(9'h1FF, 9, 0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        idle(32);
        n_cmp++;
        if (rec_q.size() != 1 || rec_q[0].d !== 9'h1FF || rec_q[0].fe !== 1'b1 || rec_q[0].pe) begin
            n_err++;
            $display("FAIL stop2_frame_err: got n=%0d d=%h fe=%b pe=%b want n=1 d=1ff fe=1 pe=0",
                     rec_q.size(), rec_q[0].d, rec_q[0].fe, rec_q[0].pe);
        end
    endtask

    task automatic test_glitch();
        set_cfg(8, 0, 1'b0, 1);
        rx_ready_i = 1'b1;
        clr();
        @(posedge clk);
        #1;
        rx_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_err++; $display("FAIL glitch_busy_seen: got %b want 1", busy_o);
        end
        idle(40);
        n_cmp++;
        if (busy_o !== 1'b0 || rec_q.size() != 0 || brk_cnt != 0) begin
            n_err++;
            $display("FAIL glitch_false_start: got busy=%b n=%0d brk=%0d want 0 0 0",
                     busy_o, rec_q.size(), brk_cnt);
        end
        // one-clock spike in the middle of data bit 3 (a 0 bit of 0xA5)
        clr();
        send_frame(9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0, 4 * OVS + OVS / 2);
        idle(32);
        n_cmp++;
        if (rec_q.size() != 1 || rec_q[0].d !== 9'h0A5) begin
            n_err++;
            $display("FAIL spike_masked: got n=%0d d=%h want n=1 d=0a5", rec_q.size(), rec_q[0].d);
        end
    endtask

    task automatic test_overrun();
        set_cfg(8, 0, 1'b0, 1);
        rx_ready_i = 1'b0;
        clr();
        send_frame(9'h011, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        idle(32);
        send_frame(9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        idle(32);
        n_cmp++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 9'h011 || ovr_cnt != 1 || rec_q.size() != 0) begin
            n_err++;
            $display("FAIL overrun_hold: got v=%b d=%h ovr=%0d n=%0d want v=1 d=011 ovr=1 n=0",
                     rx_valid_o, rx_data_o, ovr_cnt, rec_q.size());
        end
        clr();
        fork
            send_frame(9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
            begin
                @(posedge clk);
                repeat (155) @(posedge clk);
                #1;
                rx_ready_i = 1'b1;
                @(posedge clk);
                #1;
                rx_ready_i = 1'b0;
            end
        join
        idle(32);
        n_cmp++;
        if (ovr_cnt != 0 || rec_q.size() != 1 || rec_q[0].d !== 9'h011) begin
            n_err++;
            $display("FAIL ready_in_completion: got ovr=%0d n=%0d d=%h want ovr=0 n=1 d=011",
                     ovr_cnt, rec_q.size(), rec_q[0].d);
        end
        n_cmp++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 9'h022) begin
            n_err++;
            $display("FAIL new_word_loaded: got v=%b d=%h want v=1 d=022", rx_valid_o, rx_data_o);
        end
        rx_ready_i = 1'b1;
        idle(4);
        n_cmp++;
        if (rx_valid_o !== 1'b0 || rec_q.size() != 2 || rec_q[1].d !== 9'h022) begin
            n_err++;
            $display("FAIL drain: got v=%b n=%0d want v=0 n=2 second=022", rx_valid_o, rec_q.size());
        end
    endtask

    task automatic test_break();
        set_cfg(8, 0, 1'b0, 1);
        rx_ready_i = 1'b1;
        clr();
        @(posedge clk);
        #1;
        rx_i = 1'b0;
        repeat (3 * 10 * OVS) @(posedge clk);
        #1;
        rx_i = 1'b1;
        idle(64);
        n_cmp++;
        if (brk_cnt != 1 || rec_q.size() != 0 || ovr_cnt != 0) begin
            n_err++;
            $display("FAIL break_pulse: got brk=%0d n=%0d ovr=%0d want 1 0 0",
                     brk_cnt, rec_q.size(), ovr_cnt);
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL break_idle: got busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_enable();
        set_cfg(8, 0, 1'b0, 1);
        rx_ready_i = 1'b1;
        clr();
        fork
            send_frame(9'h03C, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
            begin
                @(posedge clk);
                repeat (40) @(posedge clk);
                #1;
                en_i = 1'b0;
                @(posedge clk);
                @(negedge clk);
                n_cmp++;
                if (busy_o !== 1'b0) begin
                    n_err++; $display("FAIL disable_idle: got busy=%b want 0", busy_o);
                end
            end
        join
        idle(48);
        en_i = 1'b1;
        idle(16);
        n_cmp++;
        if (rec_q.size() != 0 || brk_cnt != 0 || ovr_cnt != 0) begin
            n_err++;
            $display("FAIL disable_discard: got n=%0d brk=%0d ovr=%0d want 0 0 0",
                     rec_q.size(), brk_cnt, ovr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        set_cfg(8, 0, 1'b0, 1);
        rx_ready_i = 1'b0;
        clr();
        send_frame(9'h05A, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        idle(32);
        n_cmp++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 9'h05A) begin
            n_err++; $display("FAIL pre_reset_word: got v=%b d=%h want v=1 d=05a", rx_valid_o, rx_data_o);
        end
        rx_i = 1'b0;
        repeat (4 * OVS) @(posedge clk);
        #1;
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_err++; $display("FAIL mid_frame_busy: got %b want 1", busy_o);
        end
        rst_i = 1'b1;
        rx_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rx_valid_o, busy_o, parity_err_o, frame_err_o, break_o, overrun_o} !== 6'b0 ||
            rx_data_o !== 9'h000) begin
            n_err++;
            $display("FAIL reset_mid_frame: got v=%b busy=%b d=%h flags=%b want all 0",
                     rx_valid_o, busy_o, rx_data_o,
                     {parity_err_o, frame_err_o, break_o, overrun_o});
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        idle(48);
        n_cmp++;
        if (busy_o !== 1'b0 || rx_valid_o !== 1'b0 || brk_cnt != 0 || ovr_cnt != 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: got busy=%b v=%b brk=%0d ovr=%0d want 0",
                     busy_o, rx_valid_o, brk_cnt, ovr_cnt);
        end
        rx_ready_i = 1'b1;
    endtask

    task automatic test_random();
        logic [8:0] d;
        logic       pbit, s1, s2, two, exp_brk, exp_pe, exp_fe;
        int         len_raw, pm, div, el, kind;
        rx_ready_i = 1'b1;
        for (int f = 0; f < 24; f++) begin
            d       = 9'($urandom);
            len_raw = int'($urandom_range(0, 15));
            pm      = int'($urandom_range(0, 7));
            two     = 1'($urandom_range(0, 1));
            div     = int'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) d = '0;
            el      = eff_len(len_raw);
            d       = d & 9'((1 << el) - 1);
            kind    = par_kind(pm);
            pbit    = par_expect(d, kind) ^ ($urandom_range(0, 3) == 0);
            s1      = ($urandom_range(0, 4) != 0);
            s2      = ($urandom_range(0, 4) != 0);
            exp_brk = (d == 0) && (kind == 0 || !pbit) && !s1;
            exp_pe  = (kind != 0) && (pbit != par_expect(d, kind));
            exp_fe  = !s1 || (two && !s2);
            set_cfg(len_raw, pm, two, div);
            clr();
            send_frame(d, el, kind, pbit, s1, s2, two, -1);
            idle(3 * OVS * ((div == 0) ? 1 : div));
            n_cmp++;
            if (exp_brk) begin
                if (brk_cnt != 1 || rec_q.size() != 0) begin
                    n_err++;
                    $display("FAIL rand_break[%0d]: got brk=%0d n=%0d want brk=1 n=0",
                             f, brk_cnt, rec_q.size());
                end
            end else if (brk_cnt != 0 || rec_q.size() != 1 || rec_q[0].d !== d ||
                         rec_q[0].pe !== exp_pe || rec_q[0].fe !== exp_fe) begin
                n_err++;
                $display("FAIL rand_word[%0d]: got n=%0d d=%h pe=%b fe=%b brk=%0d want d=%h pe=%b fe=%b",
                         f, rec_q.size(), rec_q[0].d, rec_q[0].pe, rec_q[0].fe, brk_cnt,
                         d, exp_pe, exp_fe);
            end
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        en_i       = 1'b1;
        rx_i       = 1'b1;
        rx_ready_i = 1'b0;
        set_cfg(8, 0, 1'b0, 1);
        brk_cnt = 0;
        ovr_cnt = 0;
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        idle(8);
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_break();
        test_enable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
